hazard_scoreboard: RTL

- Parametrised hazard unit for the pipelined RV32 core.
- Keeps the existing M/W→E and W→D forwarding, load-use stall, and taken-branch flush.
- Adds a registered scoreboard for one outstanding multi-cycle (MUL/DIV) operation, with fixed-latency or done-handshake completion.
- Adds a saturating stall-cycle performance counter. Sits beside the datapath and drives forward selects, stalls and flushes for the F/D/E registers.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the pipeline datapath and the hazard/scoreboard unit.
// The datapath is the master: it presents stage fields and reads back forward/stall/flush controls.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] rs1D, rs2D, rdD;
  logic              reg_writeD;
  logic              mc_startD;
  logic [ADDR_W-1:0] rs1E, rs2E, rdE;
  logic              result_srcE0;
  logic              pc_srcE;
  logic [ADDR_W-1:0] rdM, rdW;
  logic              reg_writeM, reg_writeW;
  logic              mc_done;

  logic [1:0]        forwardAE, forwardBE;
  logic              forwardAD, forwardBD;
  logic              stallF, stallD, flushD, flushE;
  logic              mc_busy;
  logic [ADDR_W-1:0] mc_pend_rd;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output rs1D, rs2D, rdD, reg_writeD, mc_startD,
    output rs1E, rs2E, rdE, result_srcE0, pc_srcE,
    output rdM, rdW, reg_writeM, reg_writeW, mc_done,
    input  forwardAE, forwardBE, forwardAD, forwardBD,
    input  stallF, stallD, flushD, flushE,
    input  mc_busy, mc_pend_rd, stall_count
  );

  modport slave (
    input  rs1D, rs2D, rdD, reg_writeD, mc_startD,
    input  rs1E, rs2E, rdE, result_srcE0, pc_srcE,
    input  rdM, rdW, reg_writeM, reg_writeW, mc_done,
    output forwardAE, forwardBE, forwardAD, forwardBD,
    output stallF, stallD, flushD, flushE,
    output mc_busy, mc_pend_rd, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined RV32 core: forwarding, load-use stall, branch flush,
// a one-entry scoreboard for an outstanding MUL/DIV, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int MC_FIXED   = 1,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave hz
);

  localparam int LAT_W = $clog2(MC_LATENCY + 1);

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  mc_state_t         mcState;
  logic [ADDR_W-1:0] pendRd;
  logic [LAT_W-1:0]  mcCount;
  logic [CNT_W-1:0]  stallCount;

  logic [1:0] fwdAE, fwdBE;
  logic       busy, lwStall, pendHit, mcStall, stallAny, stallOut;
  logic       issue, complete, fixedDone;

  assign busy = (mcState == MC_BUSY);

  // M-stage results are younger than W-stage results, so M wins when both match.
  always_comb begin
    fwdAE = 2'b00;
    if (hz.reg_writeM && (hz.rs1E != '0) && (hz.rs1E == hz.rdM))
      fwdAE = 2'b10;
    else if (hz.reg_writeW && (hz.rs1E != '0) && (hz.rs1E == hz.rdW))
      fwdAE = 2'b01;

    fwdBE = 2'b00;
    if (hz.reg_writeM && (hz.rs2E != '0) && (hz.rs2E == hz.rdM))
      fwdBE = 2'b10;
    else if (hz.reg_writeW && (hz.rs2E != '0) && (hz.rs2E == hz.rdW))
      fwdBE = 2'b01;
  end

  assign lwStall = hz.result_srcE0 && (hz.rdE != '0) &&
                   ((hz.rs1D == hz.rdE) || (hz.rs2D == hz.rdE));

  // RAW on either source, or WAW on the destination, against the pending MUL/DIV result.
  assign pendHit = busy && (pendRd != '0) &&
                   ((hz.rs1D == pendRd) || (hz.rs2D == pendRd) ||
                    (hz.reg_writeD && (hz.rdD == pendRd)));

  assign mcStall  = pendHit || (busy && hz.mc_startD);
  assign stallAny = lwStall || mcStall;
  assign stallOut = stallAny && !hz.pc_srcE;

  assign issue     = hz.mc_startD && !stallOut && !hz.pc_srcE;
  assign fixedDone = (mcCount == LAT_W'(1));
  // mc_done is a single-cycle pulse; it is only meaningful while an op is outstanding.
  assign complete  = busy && ((MC_FIXED != 0) ? fixedDone : hz.mc_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcState <= MC_IDLE;
      pendRd  <= '0;
      mcCount <= '0;
    end else begin
      case (mcState)
        MC_IDLE: begin
          if (issue) begin
            mcState <= MC_BUSY;
            pendRd  <= hz.reg_writeD ? hz.rdD : '0;
            mcCount <= LAT_W'(MC_LATENCY);
          end
        end
        MC_BUSY: begin
          if (complete) begin
            mcState <= MC_IDLE;
            pendRd  <= '0;
            mcCount <= '0;
          end else if (MC_FIXED != 0) begin
            mcCount <= mcCount - LAT_W'(1);
          end
        end
        default: begin
          mcState <= MC_IDLE;
          pendRd  <= '0;
          mcCount <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stallCount <= '0;
    else if (stallOut && (stallCount != '1))
      stallCount <= stallCount + CNT_W'(1);
  end

  assign hz.forwardAE   = fwdAE;
  assign hz.forwardBE   = fwdBE;
  assign hz.forwardAD   = hz.reg_writeW && (hz.rdW != '0) && (hz.rdW == hz.rs1D);
  assign hz.forwardBD   = hz.reg_writeW && (hz.rdW != '0) && (hz.rdW == hz.rs2D);
  assign hz.stallF      = stallOut;
  assign hz.stallD      = stallOut;
  assign hz.flushD      = hz.pc_srcE;
  assign hz.flushE      = stallAny || hz.pc_srcE;
  assign hz.mc_busy     = busy;
  assign hz.mc_pend_rd  = pendRd;
  assign hz.stall_count = stallCount;

endmodule
